// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller:
// opcodes, condition codes, FSM states, flag bit positions.
package branch_ctrl_pkg;

    localparam logic [3:0] OP_B  = 4'hC;
    localparam logic [3:0] OP_BR = 4'hD;

    localparam logic [2:0] CC_NE = 3'd0;
    localparam logic [2:0] CC_EQ = 3'd1;
    localparam logic [2:0] CC_GT = 3'd2;
    localparam logic [2:0] CC_LT = 3'd3;
    localparam logic [2:0] CC_GE = 3'd4;
    localparam logic [2:0] CC_LE = 3'd5;
    localparam logic [2:0] CC_OV = 3'd6;
    localparam logic [2:0] CC_UN = 3'd7;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FLUSH
    } state_t;

    function automatic logic is_flag_writer(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6};
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_B) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// Combinational branch condition evaluator:
// condition code x {z, v, n} -> taken.
module br_cond_eval
    import branch_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flag,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flag[FLAG_Z];
    assign v = flag[FLAG_V];
    assign n = flag[FLAG_N];

    // Decode the condition code against the current flags
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_NE: taken = !z;
            CC_EQ: taken = z;
            CC_GT: taken = !z && !n;
            CC_LT: taken = n;
            CC_GE: taken = z || !n;
            CC_LE: taken = z || n;
            CC_OV: taken = v;
            CC_UN: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: tracks in-flight flag writers,
// stalls branches until flags are final, then flushes on taken.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int FLAG_LAT     = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] id_opcode,
    input  logic [2:0] id_cond,
    input  logic [2:0] flag,
    output logic       stall,
    output logic       br_taken,
    output logic       br_reg,
    output logic       flush
);

    state_t              state;
    state_t              next_state;
    logic [FLAG_LAT-1:0] trk;
    logic [FLAG_LAT-1:0] trk_next;
    logic [1:0]          cnt;
    logic                pending;
    logic                cond_taken;
    logic                is_br;
    logic                early;
    logic                load;

    br_cond_eval u_cond_eval (
        .cond  (id_cond),
        .flag  (flag),
        .taken (cond_taken)
    );

    assign pending = |trk;
    assign is_br   = id_valid & is_branch(id_opcode);
    assign early   = !pending || (id_cond == CC_UN);
    assign load    = id_valid & is_flag_writer(id_opcode)
                   & ~stall & ~flush;

    // Age in-flight flag writers one stage per edge
    always_comb begin
        trk_next    = trk << 1;
        trk_next[0] = load;
    end

    // State, tracker and flush counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            trk   <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            trk   <= trk_next;
            if (state != ST_FLUSH && next_state == ST_FLUSH)
                cnt <= 2'(FLUSH_CYCLES - 1);
            else if (state == ST_FLUSH && cnt != 2'd0)
                cnt <= cnt - 2'd1;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (is_br) begin
                    if (!early)
                        next_state = ST_WAIT;
                    else if (cond_taken)
                        next_state = ST_FLUSH;
                end
            end
            ST_WAIT: begin
                if (!pending)
                    next_state = cond_taken ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (cnt == 2'd0)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs; forced low while reset is held
    always_comb begin
        stall    = 1'b0;
        br_taken = 1'b0;
        br_reg   = 1'b0;
        flush    = 1'b0;
        if (rst) begin
            unique case (state)
                ST_IDLE: begin
                    if (is_br && early) begin
                        br_taken = cond_taken;
                        br_reg   = cond_taken && (id_opcode == OP_BR);
                    end else if (is_br) begin
                        stall = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (pending) begin
                        stall = 1'b1;
                    end else begin
                        br_taken = cond_taken;
                        br_reg   = cond_taken && (id_opcode == OP_BR);
                    end
                end
                ST_FLUSH: flush = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
